mux_scan_sequencer: RTL and testbench

Scan controller that sits directly upstream of the team's 16:1 bit multiplexer. It drives the 4-bit select, steps through all 16 channels in Gray or binary order, and samples the mux's 1-bit output once per channel. It reassembles the 16 samples into a parallel word and hands that word downstream over a valid/ready handshake. Gray order guarantees exactly one select bit toggles per step, including the return to channel 0.

---
 rtl/mux_scan_sequencer.sv | 113 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a 16:1 bit mux through all channels and
// returns the 16 samples as one word over a valid/ready handshake.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : scan request (IDLE, or HOLD on the handshake cycle)
//   mux_bit_i     : mux output for the current sel_o
//   sel_o         : 4-bit mux select
//   busy_o        : high while scanning
//   data_o        : last completed scan, bit n sampled with sel_o == n
//   valid_o       : data_o holds an unconsumed result
//   ready_i       : downstream accepts data_o when valid_o && ready_i
module mux_scan_sequencer #(
  parameter bit          GRAY_ORDER    = 1'b1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        mux_bit_i,
  output logic [3:0]  sel_o,
  output logic        busy_o,
  output logic [15:0] data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  scan_sel;

  // Gray order flips exactly one select bit per step, 8 -> 0 included.
  assign scan_sel = GRAY_ORDER ? (step_q ^ (step_q >> 1)) : step_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    cap_d    = cap_q;
    data_d   = data_q;
    sel_o    = 4'd0;
    busy_o   = 1'b0;
    valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SCAN;
          step_d   = 4'd0;
          settle_d = SETTLE;
        end
      end
      SCAN: begin
        sel_o  = scan_sel;
        busy_o = 1'b1;
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          // Bit position follows the select value, not the visit order.
          cap_d[scan_sel] = mux_bit_i;
          if (step_q != 4'd15) begin
            step_d   = step_q + 4'd1;
            settle_d = SETTLE;
          end else begin
            state_d = HOLD;
            data_d  = cap_d;
          end
        end
      end
      HOLD: begin
        valid_o = 1'b1;
        if (ready_i) begin
          if (start_i) begin
            state_d  = SCAN;
            step_d   = 4'd0;
            settle_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      step_q   <= 4'd0;
      settle_q <= 4'd0;
      cap_q    <= 16'd0;
      data_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      cap_q    <= cap_d;
      data_q   <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed bench with a cycle model for three
// configurations (Gray/S=1, binary/S=0, Gray/S=3).
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit en = 1'b0;

  logic        rst[3];
  logic        start[3];
  logic        ready[3];
  logic        mbit[3];
  logic [3:0]  sel[3];
  logic        busy[3];
  logic        valid[3];
  logic [15:0] data[3];
  logic [15:0] pat[3];

  mux_scan_sequencer #(.GRAY_ORDER(1'b1), .SETTLE_CYCLES(1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]),
    .mux_bit_i(mbit[0]), .sel_o(sel[0]), .busy_o(busy[0]),
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]));

  mux_scan_sequencer #(.GRAY_ORDER(1'b0), .SETTLE_CYCLES(0)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]),
    .mux_bit_i(mbit[1]), .sel_o(sel[1]), .busy_o(busy[1]),
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]));

  mux_scan_sequencer #(.GRAY_ORDER(1'b1), .SETTLE_CYCLES(3)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]),
    .mux_bit_i(mbit[2]), .sel_o(sel[2]), .busy_o(busy[2]),
    .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready[2]));

  function automatic int sof(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  function automatic logic [3:0] ord(int i, int k);
    return (i != 1) ? 4'(k ^ (k >> 1)) : 4'(k);
  endfunction

  task automatic chk(string nm, int inst, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, inst, got, exp);
    end
  endtask

  // Model: 0 idle, 1 scanning (mt = cycles since start edge), 2 holding.
  int          mst[3];
  int          mt[3];
  logic [15:0] mcap[3];
  logic [15:0] mdat[3];

  always @(posedge clk) begin
    logic [15:0] c;
    int s;
    for (int i = 0; i < 3; i++) begin
      s = sof(i);
      c = mcap[i];
      if (rst[i]) begin
        mst[i]  <= 0;
        mt[i]   <= 0;
        mcap[i] <= 16'd0;
        mdat[i] <= 16'd0;
      end else if (mst[i] == 0) begin
        if (start[i]) begin
          mst[i] <= 1;
          mt[i]  <= 0;
        end
      end else if (mst[i] == 1) begin
        if (mt[i] % (s + 1) == s)
          c[ord(i, mt[i] / (s + 1))] = pat[i][ord(i, mt[i] / (s + 1))];
        mcap[i] <= c;
        if (mt[i] == 16 * (s + 1) - 1) begin
          mst[i]  <= 2;
          mdat[i] <= c;
        end else begin
          mt[i] <= mt[i] + 1;
        end
      end else begin
        if (ready[i]) begin
          mst[i] <= start[i] ? 1 : 0;
          mt[i]  <= 0;
        end
      end
    end
  end

  // Mux stand-in: true channel bit only on sampling cycles, noise otherwise.
  always @(negedge clk) begin
    int s;
    #1;
    for (int i = 0; i < 3; i++) begin
      s = sof(i);
      if (mst[i] == 1 && (mt[i] % (s + 1) == s))
        mbit[i] = pat[i][sel[i]];
      else
        mbit[i] = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        chk("m_sel", i, 32'(sel[i]),
            32'((mst[i] == 1) ? ord(i, mt[i] / (sof(i) + 1)) : 4'd0));
        chk("m_busy", i, 32'(busy[i]), 32'(mst[i] == 1));
        chk("m_valid", i, 32'(valid[i]), 32'(mst[i] == 2));
        chk("m_data", i, 32'(data[i]), 32'(mdat[i]));
      end
    end
  end

  int          rise;
  logic [15:0] rdata;
  logic        vafter;
  logic [3:0]  sq[0:80];
  int          gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4,
                            12, 13, 15, 14, 10, 11, 9, 8};

  task automatic run_scan(input int i, input int lim);
    rise   = -1;
    vafter = 1'bx;
    start[i] = 1'b1;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (n == 1) start[i] = 1'b0;
      sq[n] = sel[i];
      if (rise > 0 && n == rise + 1) vafter = valid[i];
      if (valid[i] && rise < 0) begin
        rise  = n;
        rdata = data[i];
      end
    end
  endtask

  initial begin
    int bad, tog, chg, k1, k2;
    bit found;
    logic [3:0] d;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; ready[i] = 1'b0; pat[i] = 16'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_sel", i, 32'(sel[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_valid", i, 32'(valid[i]), 32'd0);
      chk("rst_data", i, 32'(data[i]), 32'd0);
      rst[i] = 1'b0;
    end
    en = 1'b1;

    // Gray, settle 1, static pattern.
    pat[0] = 16'hA5C3; ready[0] = 1'b1;
    run_scan(0, 40);
    chk("t1_rise", 0, 32'(rise - 1), 32'd32);
    chk("t1_data", 0, 32'(rdata), 32'hA5C3);
    chk("t1_pulse", 0, 32'(vafter), 32'd0);
    bad = 0; tog = 0; chg = 0;
    for (int n = 1; n <= 32; n++) begin
      if (32'(sq[n]) != 32'(gseq[(n - 1) / 2])) bad++;
      d = sq[n] ^ sq[n + 1];
      if (d != 4'd0) begin
        chg++;
        if ($countones(d) != 1) tog++;
      end
    end
    chk("t1_gray_seq", 0, 32'(bad), 32'd0);
    chk("t1_one_bit", 0, 32'(tog), 32'd0);
    chk("t1_changes", 0, 32'(chg), 32'd16);
    chk("t1_wrap", 0, 32'({sq[32], sq[33]}), 32'h80);

    // Binary, settle 0.
    pat[1] = 16'h8001; ready[1] = 1'b1;
    run_scan(1, 24);
    chk("t2_rise", 1, 32'(rise - 1), 32'd16);
    chk("t2_data", 1, 32'(rdata), 32'h8001);
    bad = 0;
    for (int n = 1; n <= 16; n++)
      if (32'(sq[n]) != 32'(n - 1)) bad++;
    chk("t2_bin_seq", 1, 32'(bad), 32'd0);

    // Backpressure.
    pat[0] = 16'h3C5A; ready[0] = 1'b0;
    run_scan(0, 40);
    chk("t3_rise", 0, 32'(rise - 1), 32'd32);
    chk("t3_data", 0, 32'(rdata), 32'h3C5A);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_valid", 0, 32'(valid[0]), 32'd1);
      chk("t3_hold", 0, 32'(data[0]), 32'h3C5A);
      chk("t3_sel", 0, 32'(sel[0]), 32'd0);
      chk("t3_busy", 0, 32'(busy[0]), 32'd0);
      start[0] = (k == 3);
    end
    start[0] = 1'b0; ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_drop", 0, 32'(valid[0]), 32'd0);
    chk("t3_idle", 0, 32'(busy[0]), 32'd0);

    // Back-to-back.
    pat[0] = 16'h1234; start[0] = 1'b1;
    k1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid[0]) begin k1 = k; break; end
    end
    chk("t4_first", 0, 32'(k1 != 0), 32'd1);
    chk("t4_d1", 0, 32'(data[0]), 32'h1234);
    pat[0] = 16'hFEDC;
    @(negedge clk);
    chk("t4_rescan", 0, 32'(busy[0]), 32'd1);
    chk("t4_vdrop", 0, 32'(valid[0]), 32'd0);
    k2 = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (valid[0]) begin k2 = k; break; end
    end
    chk("t4_period", 0, 32'(k2), 32'd33);
    chk("t4_d2", 0, 32'(data[0]), 32'hFEDC);
    start[0] = 1'b0;
    @(negedge clk);
    chk("t4_end", 0, 32'(valid[0] | busy[0]), 32'd0);

    // Reset at step 7 (Gray select 4).
    start[0] = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (sel[0] == 4'd4) begin found = 1'b1; break; end
    end
    chk("t5_step7", 0, 32'(found), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5_sel", 0, 32'(sel[0]), 32'd0);
    chk("t5_busy", 0, 32'(busy[0]), 32'd0);
    chk("t5_valid", 0, 32'(valid[0]), 32'd0);
    chk("t5_data", 0, 32'(data[0]), 32'd0);
    pat[0] = 16'h0F0F;
    run_scan(0, 40);
    chk("t5_rise", 0, 32'(rise - 1), 32'd32);
    chk("t5_new", 0, 32'(rdata), 32'h0F0F);

    // Settle 3 with noise on every non-final hold cycle.
    pat[2] = 16'h6A95; ready[2] = 1'b1;
    run_scan(2, 70);
    chk("t6_rise", 2, 32'(rise - 1), 32'd64);
    chk("t6_data", 2, 32'(rdata), 32'h6A95);
    chk("t6_pulse", 2, 32'(vafter), 32'd0);
    bad = 0;
    for (int n = 1; n <= 64; n++)
      if (32'(sq[n]) != 32'(gseq[(n - 1) / 4])) bad++;
    chk("t6_seq", 2, 32'(bad), 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
